mem_bus_if: RTL and testbench
=============================

Name: mem_bus_if

Overview:
- Memory access unit directly downstream of the multicycle controller.
- Turns the controller's level-held MemRead/MemWrite (address from the IorD mux, write data from RegIn path) into a req/ack transaction on the external memory bus.
- Returns read data to the IR/MDR path and asserts stall so the controller holds its current state until the access completes.
- Detects illegal requests, bus errors and timeouts; reports them through a sticky fault code.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles in REQ waiting for bus_ack before abort (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  read request from controller, held high while controller state wants a read
- mem_write  in  1  write request from controller, held similarly
- addr  in  ADDR_W  byte address (IorD mux output)
- wdata  in  DATA_W  store data
- rdata  out  DATA_W  read data, registered, valid in DONE and held until the next read completes
- stall  out  1  controller must not advance state while high
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 illegal request, 2 timeout, 3 bus error; first fault wins
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  ADDR_W  registered, word-aligned
- bus_wdata  out  DATA_W  registered
- bus_ack  in  1  transaction complete, one-cycle pulse
- bus_err  in  1  qualifies bus_ack; error response
- bus_rdata  in  DATA_W  valid when bus_ack=1

Behaviour:
- Reset (async, any state): state=IDLE. bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0, fault=0, fault_code=0, timer=0. stall follows combinational rule below.
- States: IDLE, REQ, DONE.
- stall (combinational) = (IDLE & (mem_read | mem_write)) | REQ. stall=0 in DONE.
- IDLE, no request: stay in IDLE.
- IDLE, legal request (exactly one of mem_read/mem_write, addr[1:0]==0):
  - capture addr, wdata and we=mem_write into the bus_* registers;
  - bus_req<=1, timer<=0, go to REQ.
- IDLE, illegal request (both rd and wr high, or addr[1:0]!=0):
  - no bus transaction;
  - set fault/fault_code=1 if fault==0;
  - go to DONE with rdata unchanged, so the controller advances.
- REQ:
  - bus_req stays 1; bus_addr/bus_we/bus_wdata are stable; timer increments each cycle.
  - bus_ack=1, bus_err=0: bus_req<=0; rdata<=bus_rdata if read (unchanged on write); go to DONE.
  - bus_ack=1, bus_err=1: bus_req<=0; rdata<=0 if read; fault_code=3 (first wins); go to DONE.
  - timer==TIMEOUT-1 with no ack: bus_req<=0; rdata<=0 if read; fault_code=2 (first wins); go to DONE.
  - ack in the same cycle as timeout: the ack wins.
- DONE:
  - lasts exactly one cycle with stall=0; the controller advances on this edge.
  - mem_read/mem_write are ignored in DONE, even if still high, so a held request is not re-issued.
  - next state is IDLE.
- Latency: request seen in cycle 0, bus_req high from cycle 1, ack in cycle k (k>=1), DONE in cycle k+1, rdata valid at k+1. Minimum 3 cycles per access; 2 stall cycles with zero-wait ack.
- bus_ack arriving outside REQ is ignored.
- fault clears only on rst.

Decomposition:
- Package mem_bus_pkg:
  - state enum {IDLE, REQ, DONE};
  - fault code constants FLT_NONE=0, FLT_ILLEGAL=1, FLT_TIMEOUT=2, FLT_BUSERR=3.
- One sub-module wait_timer:
  - clear/enable counter with parameter TIMEOUT;
  - outputs expired = (count==TIMEOUT-1).
  - Instantiated once; cleared on IDLE->REQ, enabled in REQ.

Test Plan:
- Reset during REQ (bus_req=1): rst pulse -> bus_req=0 the same cycle (async), state IDLE, fault=0, rdata=0.
- Read addr=0x100, bus_ack in cycle 1 with bus_rdata=0xCAFEF00D -> stall high in cycles 0-1, bus_req high only in cycle 1, rdata=0xCAFEF00D and stall=0 in cycle 2, back to IDLE in cycle 3, no second bus_req while mem_read stays high in cycle 2.
- Write addr=0x204, wdata=0x12345678, ack after 5 wait cycles -> bus_we=1 and bus_addr/bus_wdata stable for all 6 REQ cycles, stall=0 only in the DONE cycle, rdata unchanged.
- Misaligned read addr=0x102 -> no bus_req, DONE in cycle 1, fault=1, fault_code=1.
- Then a legal read answered with bus_err=1 -> rdata=0, fault_code stays 1 (first wins).
- TIMEOUT=4, read with no ack -> bus_req high for 4 cycles then low, rdata=0, fault_code=2, stall drops in DONE.
- Timeout-boundary ack: ack in the last REQ cycle -> normal completion with rdata=bus_rdata, no fault.
- Both mem_read and mem_write high -> fault_code=1, no bus_req.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus interface: FSM states,
// fault codes and the request legality check.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL = 2'd1;
    localparam logic [1:0] FLT_TIMEOUT = 2'd2;
    localparam logic [1:0] FLT_BUSERR  = 2'd3;

    // A request is legal when exactly one of read/write is asserted and the
    // byte address is word aligned.
    function automatic logic is_legal(input logic rd, input logic wr,
                                      input logic [1:0] addr_lsb);
        return (rd ^ wr) && (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Clear/enable cycle counter; expired flags the last permitted wait cycle.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_if.sv
// Converts the controller's level-held mem_read/mem_write into one req/ack
// bus transaction, stalling the controller until the access completes.
//
// Bus handshake: bus_req rises the cycle after a legal request is seen and
// stays high, with bus_we/bus_addr/bus_wdata stable, until the cycle in which
// bus_ack pulses (bus_err qualifies it, bus_rdata is valid with it) or the
// wait timer expires; bus_ack outside REQ is ignored.
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        dbg_state
);

    state_t state, state_nxt;

    logic start, illegal, finish_ok, finish_err, finish_to;
    logic timer_clr, timer_en, timer_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        start      = 1'b0;
        illegal    = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        finish_to  = 1'b0;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    stall = 1'b1;
                    if (is_legal(mem_read, mem_write, addr[1:0])) begin
                        start     = 1'b1;
                        timer_clr = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        illegal   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            REQ: begin
                stall    = 1'b1;
                timer_en = 1'b1;
                // An ack in the final timer cycle still completes normally.
                if (bus_ack) begin
                    finish_ok  = !bus_err;
                    finish_err = bus_err;
                    state_nxt  = DONE;
                end else if (timer_expired) begin
                    finish_to = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= addr;
                bus_wdata <= wdata;
            end
            if (finish_ok || finish_err || finish_to) begin
                bus_req <= 1'b0;
            end
            if (finish_ok && !bus_we) begin
                rdata <= bus_rdata;
            end else if ((finish_err || finish_to) && !bus_we) begin
                rdata <= '0;
            end
        end
    end

    // Sticky fault: only the first fault since reset is recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else if (!fault) begin
            if (illegal) begin
                fault      <= 1'b1;
                fault_code <= FLT_ILLEGAL;
            end else if (finish_err) begin
                fault      <= 1'b1;
                fault_code <= FLT_BUSERR;
            end else if (finish_to) begin
                fault      <= 1'b1;
                fault_code <= FLT_TIMEOUT;
            end
        end
    end

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(timer_expired)
    );

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: drives controller requests and bus responses,
// checks bus-side timing inline and completed accesses through an expected queue.
module tb_mem_bus_if;

    localparam int TO = 8;
    localparam int EW = 32 + 1 + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic [1:0]  fault_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'hDEADDEAD;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    mem_bus_if #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .fault_code(fault_code),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .bus_rdata (bus_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // mode: 0 = no ack (timeout), 1 = ack, 2 = ack with bus_err.
    // waits: cycles in REQ before the ack cycle.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int waits, input int mode,
                             input logic [31:0] brd,
                             input logic [31:0] exp_rd, input logic exp_f,
                             input logic [1:0] exp_c);
        logic legal;
        int n;
        exp_q.push_back({exp_rd, exp_f, exp_c});
        legal = (rd ^ wr) && (a[1:0] == 2'b00);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        #1;
        chk("stall_c0", 32'(stall), 32'd1);
        chk("bus_req_c0", 32'(bus_req), 32'd0);
        if (legal) begin
            n = (mode == 0) ? TO : waits + 1;
            for (int c = 1; c <= n; c++) begin
                @(posedge clk); #1;
                chk("bus_req_req", 32'(bus_req), 32'd1);
                chk("bus_we_req", 32'(bus_we), 32'(wr));
                chk("bus_addr_req", bus_addr, a);
                chk("bus_wdata_req", bus_wdata, wd);
                chk("stall_req", 32'(stall), 32'd1);
                if (mode != 0 && c == n) begin
                    bus_ack = 1'b1;
                    bus_err = (mode == 2);
                    bus_rdata = brd;
                end
            end
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'hDEADDEAD;
        chk("bus_req_done", 32'(bus_req), 32'd0);
        chk("stall_done", 32'(stall), 32'd0);
        chk("state_done", 32'(dbg_state), 32'd2);
        @(posedge clk); #1;
        chk("no_reissue", 32'(bus_req), 32'd0);
        chk("state_idle", 32'(dbg_state), 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("stall_idle", 32'(stall), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && dbg_state == 2'd2) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE with rdata %h, expected no completion", rdata);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rdata", rdata, e[34:3]);
                chk("sb_fault", 32'(fault), 32'(e[2]));
                chk("sb_fault_code", 32'(fault_code), 32'(e[1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // zero-wait read
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2'd0);
        // write with 5 wait cycles, rdata keeps the last read value
        do_access(1'b0, 1'b1, 32'h204, 32'h12345678, 5, 1, 32'h0, 32'hCAFEF00D, 1'b0, 2'd0);
        // ack in the very last REQ cycle beats the timeout
        do_access(1'b1, 1'b0, 32'h008, 32'h0, TO - 1, 1, 32'h0BADBEEF, 32'h0BADBEEF, 1'b0, 2'd0);
        // misaligned read -> illegal
        do_access(1'b1, 1'b0, 32'h102, 32'h0, 0, 1, 32'h0, 32'h0BADBEEF, 1'b1, 2'd1);
        // bus error read: rdata cleared, code stays illegal
        do_access(1'b1, 1'b0, 32'h10C, 32'h0, 1, 2, 32'hFFFFFFFF, 32'h0, 1'b1, 2'd1);
        // normal read still works with sticky fault set
        do_access(1'b1, 1'b0, 32'h110, 32'h0, 2, 1, 32'h55AA55AA, 32'h55AA55AA, 1'b1, 2'd1);

        // stray ack while idle is ignored
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h77777777;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'hDEADDEAD;
        chk("stray_ack_rdata", rdata, 32'h55AA55AA);
        chk("stray_ack_state", 32'(dbg_state), 32'd0);
        chk("stray_ack_bus_req", 32'(bus_req), 32'd0);

        // asynchronous reset in the middle of REQ
        mem_read = 1'b1; addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
        mem_read = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_bus_req", 32'(bus_req), 32'd0);
        chk("async_rst_state", 32'(dbg_state), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        chk("async_rst_fault_code", 32'(fault_code), 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // timeout: no ack for TO cycles
        do_access(1'b1, 1'b0, 32'h120, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 2'd2);
        // later illegal write keeps the timeout code
        do_access(1'b0, 1'b1, 32'h205, 32'hA5A5A5A5, 0, 1, 32'h0, 32'h0, 1'b1, 2'd2);

        // reset pulse, then read and write together -> illegal
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_access(1'b1, 1'b1, 32'h040, 32'h0, 0, 1, 32'h0, 32'h0, 1'b1, 2'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
